isi_shaping_lf_n: RTL



---
 rtl/isi_shaping_lf_n.sv | 101 ++++++++++
 1 files changed

// File: rtl/isi_shaping_lf_n.sv
`default_nettype none
// ============================================================================
// Module   : isi_shaping_lf_n
// Brief    : N-channel 1st/2nd-order ISI shaping loop filter with
//            common-minimum removal and saturating, sticky-flagged outputs.
// Revision : 1.0
// ============================================================================
module isi_shaping_lf_n #(
  parameter int N_CH = 6,
  parameter int W    = 4
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              en,
  input  logic              clr,
  input  logic              ord2,
  input  logic [N_CH-1:0]   st,
  output logic [N_CH*W-1:0] sfi,
  output logic [W+2:0]      su,
  output logic              ovf
);

  localparam int SW = W + 3;
  localparam logic signed [SW-1:0] c_fmax = SW'((1 << W) - 1);

  logic [W-1:0]          r_fid1 [N_CH];
  logic [W-1:0]          r_fid2 [N_CH];
  logic                  r_ord2;
  logic                  r_ovf;

  logic signed [SW-1:0]  w_sr [N_CH];
  logic signed [SW-1:0]  w_fi [N_CH];
  logic signed [SW-1:0]  w_su;
  logic [W-1:0]          w_sfi_ch [N_CH];
  logic [N_CH-1:0]       w_sat;
  logic                  w_any_sat;

  // SW = W+3 bits covers every intermediate without wrap, so operands are
  // simply zero-extended into the signed domain.
  for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
    logic signed [SW-1:0] w_stx;
    logic signed [SW-1:0] w_f1x;
    logic signed [SW-1:0] w_f2x;

    assign w_stx = $signed({{(SW-1){1'b0}}, st[gi]});
    assign w_f1x = $signed({{(SW-W){1'b0}}, r_fid1[gi]});
    assign w_f2x = $signed({{(SW-W){1'b0}}, r_fid2[gi]});

    assign w_sr[gi] = r_ord2 ? (w_stx + (w_f1x <<< 1) - w_f2x)
                             : (w_stx + w_f1x);

    assign w_fi[gi]     = w_sr[gi] - w_su;
    assign w_sat[gi]    = (w_fi[gi] > c_fmax);
    assign w_sfi_ch[gi] = w_sat[gi] ? {W{1'b1}} : w_fi[gi][W-1:0];
    assign sfi[gi*W +: W] = w_sfi_ch[gi];
  end

  always_comb begin
    w_su = w_sr[0];
    for (int i = 1; i < N_CH; i++) begin
      if (w_sr[i] < w_su) w_su = w_sr[i];
    end
  end

  assign w_any_sat = |w_sat;
  assign su        = w_su;
  assign ovf       = r_ovf;

  // A mode change restarts the filter from zero; ovf survives it, clr does not.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < N_CH; i++) begin
        r_fid1[i] <= '0;
        r_fid2[i] <= '0;
      end
      r_ord2 <= 1'b0;
      r_ovf  <= 1'b0;
    end else if (clr) begin
      for (int i = 0; i < N_CH; i++) begin
        r_fid1[i] <= '0;
        r_fid2[i] <= '0;
      end
      r_ord2 <= ord2;
      r_ovf  <= 1'b0;
    end else if (ord2 != r_ord2) begin
      for (int i = 0; i < N_CH; i++) begin
        r_fid1[i] <= '0;
        r_fid2[i] <= '0;
      end
      r_ord2 <= ord2;
    end else if (en) begin
      for (int i = 0; i < N_CH; i++) begin
        r_fid2[i] <= r_fid1[i];
        r_fid1[i] <= w_sfi_ch[i];
      end
      r_ovf <= r_ovf | w_any_sat;
    end
  end

endmodule
`default_nettype wire
